// File: rtl/capture_pkg.sv
// Shared types and constants for the logic-analyzer capture controller.
package capture_pkg;

  // Encoded acquisition state; the encoding is visible in the status register.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_PRETRIG   = 3'd2,
    ST_WAIT_TRIG = 3'd3,
    ST_POSTTRIG  = 3'd4,
    ST_DONE      = 3'd5
  } capture_state_t;

  localparam int CAP_ADDR_W_DEF   = 10;
  localparam int CAP_SAMPLE_W_DEF = 8;

  // Number of entries in the circular sample RAM for a given address width.
  function automatic int cap_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/circ_addr_counter.sv
// Wrapping write-address pointer for the circular sample RAM, plus a
// modular subtractor used to derive the oldest valid sample address.
module circ_addr_counter #(
  parameter int AW = 10
) (
  input  logic          system_clock,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  input  logic [AW-1:0] sub_a,
  input  logic [AW-1:0] sub_b,
  output logic [AW-1:0] sub_diff
);

  logic [AW-1:0] addr_q, addr_d;

  // Next pointer: clear wins; increment wraps DEPTH-1 -> 0 by natural overflow.
  always_comb begin
    addr_d = addr_q;
    if (clr)      addr_d = '0;
    else if (inc) addr_d = addr_q + AW'(1);
  end

  // Pointer register.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr_d;
  end

  assign addr = addr_q;

  // Modulo-DEPTH difference: AW-bit arithmetic discards the borrow.
  assign sub_diff = sub_a - sub_b;

endmodule

// File: rtl/capture_controller.sv
// Acquisition sequencer: arms sampler/trigger, fills the pre-trigger window,
// waits for run, captures post-trigger samples into a circular RAM and
// reports trigger / readout-start addresses.
module capture_controller
  import capture_pkg::*;
#(
  parameter int ADDR_WIDTH   = CAP_ADDR_W_DEF,
  parameter int SAMPLE_WIDTH = CAP_SAMPLE_W_DEF
) (
  input  logic                    system_clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   pre_count,
  input  logic [ADDR_WIDTH-1:0]   post_count,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    run,
  output logic                    arm,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [SAMPLE_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  output logic [ADDR_WIDTH-1:0]   start_addr,
  output logic                    done,
  output logic                    busy,
  output logic [2:0]              state
);

  capture_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pre_q, pre_d;
  logic [ADDR_WIDTH-1:0]   post_q, post_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   trig_q, trig_d;
  logic [ADDR_WIDTH-1:0]   saddr_q, saddr_d;

  logic                    ptr_clr, ptr_inc, take;
  logic [ADDR_WIDTH-1:0]   ptr, sub_a, sub_diff, room, post_sat, cnt_inc;

  // ptr is the address the next accepted sample will be written to.
  circ_addr_counter #(.AW(ADDR_WIDTH)) u_ptr (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .clr          (ptr_clr),
    .inc          (ptr_inc),
    .addr         (ptr),
    .sub_a        (sub_a),
    .sub_b        (pre_q),
    .sub_diff     (sub_diff)
  );

  // Trigger address feeding the start_addr subtractor. In WAIT_TRIG the trigger
  // lands at ptr this cycle; afterwards the registered value is stable. Taken
  // from registers only so the subtractor stays out of the FSM's comb path.
  assign sub_a = (state_q == ST_WAIT_TRIG) ? ptr : trig_q;

  // Post window is limited so pre + post never exceeds DEPTH-1 samples.
  assign room     = ADDR_WIDTH'(cap_depth(ADDR_WIDTH) - 1) - pre_count;
  assign post_sat = (post_count > room) ? room : post_count;
  assign cnt_inc  = cnt_q + ADDR_WIDTH'(1);

  // FSM next-state, sample counting and write generation; abort overrides all.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    post_d    = post_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    trig_d    = trig_q;
    saddr_d   = saddr_q;
    ptr_clr   = 1'b0;
    take      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ARM;
          pre_d   = pre_count;
          post_d  = post_sat;
        end
      end
      ST_ARM: begin
        ptr_clr   = 1'b1;
        wr_addr_d = '0;
        cnt_d     = '0;
        trig_d    = '0;
        saddr_d   = '0;
        state_d   = (pre_q == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
      end
      ST_PRETRIG: begin
        if (sample_valid) begin
          take  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == pre_q) state_d = ST_WAIT_TRIG;
        end
      end
      ST_WAIT_TRIG: begin
        if (sample_valid) begin
          if (run) begin
            trig_d = ptr;
            if (post_q == '0) begin
              // Zero-length post window: the trigger sample is not stored.
              state_d = ST_DONE;
            end else begin
              take    = 1'b1;
              cnt_d   = ADDR_WIDTH'(1);
              state_d = (post_q == ADDR_WIDTH'(1)) ? ST_DONE : ST_POSTTRIG;
            end
          end else begin
            take = 1'b1;
          end
        end
      end
      ST_POSTTRIG: begin
        if (sample_valid) begin
          take  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == post_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr;
      wr_data_d = sample_in;
    end

    // start_addr is captured once, on the transition into DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) saddr_d = sub_diff;

    if (abort) begin
      state_d   = ST_IDLE;
      take      = 1'b0;
      ptr_clr   = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      trig_d    = '0;
      saddr_d   = '0;
    end
  end

  assign ptr_inc = take;

  // State, configuration, counter and output registers.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      post_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      trig_q    <= '0;
      saddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      trig_q    <= trig_d;
      saddr_q   <= saddr_d;
    end
  end

  assign arm        = (state_q == ST_ARM);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_ARM) || (state_q == ST_PRETRIG) ||
                      (state_q == ST_WAIT_TRIG) || (state_q == ST_POSTTRIG);
  assign state      = state_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign trig_addr  = trig_q;
  assign start_addr = saddr_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: a 10-bit-address instance for the
// main scenarios and a 4-bit-address instance for wrap and saturation.
module tb_capture_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (ADDR_WIDTH=10)
  logic       start_a = 0, abort_a = 0, sv_a = 0, run_a = 0;
  logic [9:0] pre_a = 0, post_a = 0;
  logic [7:0] sin_a = 0;
  logic       arm_a, wr_en_a, done_a, busy_a;
  logic [9:0] wr_addr_a, trig_a, saddr_a;
  logic [7:0] wr_data_a;
  logic [2:0] state_a;

  // Instance B (ADDR_WIDTH=4)
  logic       start_b = 0, abort_b = 0, sv_b = 0, run_b = 0;
  logic [3:0] pre_b = 0, post_b = 0;
  logic [7:0] sin_b = 0;
  logic       arm_b, wr_en_b, done_b, busy_b;
  logic [3:0] wr_addr_b, trig_b, saddr_b;
  logic [7:0] wr_data_b;
  logic [2:0] state_b;

  capture_controller #(.ADDR_WIDTH(10), .SAMPLE_WIDTH(8)) dut_a (
    .system_clock(clk), .reset_n(rst_n), .start(start_a), .abort(abort_a),
    .pre_count(pre_a), .post_count(post_a), .sample_in(sin_a),
    .sample_valid(sv_a), .run(run_a), .arm(arm_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .trig_addr(trig_a),
    .start_addr(saddr_a), .done(done_a), .busy(busy_a), .state(state_a));

  capture_controller #(.ADDR_WIDTH(4), .SAMPLE_WIDTH(8)) dut_b (
    .system_clock(clk), .reset_n(rst_n), .start(start_b), .abort(abort_b),
    .pre_count(pre_b), .post_count(post_b), .sample_in(sin_b),
    .sample_valid(sv_b), .run(run_b), .arm(arm_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .trig_addr(trig_b),
    .start_addr(saddr_b), .done(done_b), .busy(busy_b), .state(state_b));

  // Write logs, sampled on the falling edge.
  int wa_addr[$];
  int wa_data[$];
  int wb_addr[$];
  always @(negedge clk) begin
    if (wr_en_a) begin
      wa_addr.push_back(int'(wr_addr_a));
      wa_data.push_back(int'(wr_data_a));
    end
    if (wr_en_b) wb_addr.push_back(int'(wr_addr_b));
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample on A followed by `gap` idle cycles.
  task automatic samp_a(input int d, input logic r, input int gap);
    sv_a = 1'b1; sin_a = 8'(d); run_a = r;
    tick();
    sv_a = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base, bad;

    // ---- Reset with random inputs ----
    rst_n = 1'b0;
    repeat (3) begin
      start_a = 1'($urandom); abort_a = 1'($urandom); sv_a = 1'($urandom);
      run_a = 1'($urandom); pre_a = 10'($urandom); post_a = 10'($urandom);
      sin_a = 8'($urandom);
      tick();
    end
    chk("rst_arm", 32'(arm_a), 0);
    chk("rst_wr_en", 32'(wr_en_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_state", 32'(state_a), 0);
    chk("rst_wr_addr", 32'(wr_addr_a), 0);
    chk("rst_trig", 32'(trig_a), 0);
    chk("rst_start_addr", 32'(saddr_a), 0);
    start_a = 0; abort_a = 0; sv_a = 0; run_a = 0; pre_a = 0; post_a = 0;
    rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(state_a), 0);

    // ---- Basic capture: pre=4 post=3, trigger at sample 10 ----
    base = wa_addr.size();
    pre_a = 10'd4; post_a = 10'd3; start_a = 1'b1;
    tick();
    chk("basic_arm", 32'(arm_a), 1);
    chk("basic_state_arm", 32'(state_a), 1);
    chk("basic_busy", 32'(busy_a), 1);
    start_a = 1'b0; pre_a = 10'd50; post_a = 10'd50;   // must be ignored
    tick();
    chk("basic_arm_one_cycle", 32'(arm_a), 0);
    chk("basic_state_pre", 32'(state_a), 2);
    sv_a = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      sin_a = 8'(k); run_a = (k >= 10);
      tick();
      if (k == 3) chk("basic_wait_entry", 32'(state_a), 3);
      if (k == 10) chk("basic_post_entry", 32'(state_a), 4);
    end
    chk("basic_done_state", 32'(state_a), 5);
    chk("basic_last_wr_en", 32'(wr_en_a), 1);
    chk("basic_last_addr", 32'(wr_addr_a), 12);
    sv_a = 1'b0; run_a = 1'b0;
    tick();
    chk("basic_done", 32'(done_a), 1);
    chk("basic_done_busy", 32'(busy_a), 0);
    chk("basic_done_wr_en", 32'(wr_en_a), 0);
    chk("basic_trig", 32'(trig_a), 10);
    chk("basic_start_addr", 32'(saddr_a), 6);
    chk("basic_nwrites", 32'(wa_addr.size() - base), 13);
    bad = 0;
    for (int i = 0; i < 13 && base + i < wa_addr.size(); i++)
      if (wa_addr[base+i] != i || wa_data[base+i] != i) bad++;
    chk("basic_addr_data_seq", 32'(bad), 0);

    // ---- Early trigger: run high at arm, ignored during PRETRIG ----
    base = wa_addr.size();
    pre_a = 10'd4; post_a = 10'd2; run_a = 1'b1; start_a = 1'b1;
    tick();
    chk("early_rearm", 32'(state_a), 1);
    start_a = 1'b0;
    tick();
    sv_a = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      sin_a = 8'(k);
      tick();
      if (k == 2) chk("early_still_pre", 32'(state_a), 2);
    end
    chk("early_done_state", 32'(state_a), 5);
    sv_a = 1'b0;
    tick();
    chk("early_trig", 32'(trig_a), 4);
    chk("early_start_addr", 32'(saddr_a), 0);
    chk("early_nwrites", 32'(wa_addr.size() - base), 6);

    // ---- Abort during POSTTRIG with a valid sample ----
    base = wa_addr.size();
    pre_a = 10'd2; post_a = 10'd5; run_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    sv_a = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      sin_a = 8'(k);
      tick();
    end
    chk("abort_in_post", 32'(state_a), 4);
    abort_a = 1'b1; sin_a = 8'd4;
    tick();
    chk("abort_state", 32'(state_a), 0);
    chk("abort_wr_en", 32'(wr_en_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_trig", 32'(trig_a), 0);
    abort_a = 1'b0; sv_a = 1'b0; run_a = 1'b0;
    tick();
    chk("abort_nwrites", 32'(wa_addr.size() - base), 4);
    chk("abort_done_stays", 32'(done_a), 0);

    // ---- pre=0/post=0, start ignored while busy ----
    base = wa_addr.size();
    pre_a = 10'd0; post_a = 10'd0; start_a = 1'b1;
    tick();
    chk("zero_rearm_after_abort", 32'(arm_a), 1);
    start_a = 1'b0;
    tick();
    chk("zero_direct_wait", 32'(state_a), 3);
    sv_a = 1'b1; sin_a = 8'hA0; start_a = 1'b1;
    tick();
    chk("zero_start_ignored", 32'(state_a), 3);
    chk("zero_no_arm", 32'(arm_a), 0);
    start_a = 1'b0; sin_a = 8'hA1;
    tick();
    run_a = 1'b1; sin_a = 8'hA2;
    tick();
    chk("zero_done_state", 32'(state_a), 5);
    chk("zero_no_trig_write", 32'(wr_en_a), 0);
    sv_a = 1'b0; run_a = 1'b0;
    tick();
    chk("zero_trig", 32'(trig_a), 2);
    chk("zero_start_addr", 32'(saddr_a), 2);
    chk("zero_nwrites", 32'(wa_addr.size() - base), 2);

    // ---- Sparse valid, run dropping mid-POSTTRIG ----
    base = wa_addr.size();
    pre_a = 10'd2; post_a = 10'd2; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    samp_a(0, 1'b0, 2);
    chk("sparse_pre_hold", 32'(state_a), 2);
    samp_a(1, 1'b0, 2);
    chk("sparse_wait", 32'(state_a), 3);
    samp_a(2, 1'b1, 2);
    chk("sparse_post", 32'(state_a), 4);
    chk("sparse_trig", 32'(trig_a), 2);
    samp_a(3, 1'b0, 2);
    chk("sparse_done", 32'(state_a), 5);
    chk("sparse_start_addr", 32'(saddr_a), 0);
    chk("sparse_nwrites", 32'(wa_addr.size() - base), 4);

    // ---- Async reset mid-acquisition ----
    pre_a = 10'd3; post_a = 10'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    sv_a = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_a), 0);
    chk("arst_wr_en", 32'(wr_en_a), 0);
    chk("arst_wr_addr", 32'(wr_addr_a), 0);
    chk("arst_trig", 32'(trig_a), 0);
    sv_a = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Wrap on 4-bit instance: pre=5 post=4, trigger at sample 20 ----
    base = wb_addr.size();
    pre_b = 4'd5; post_b = 4'd4; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    sv_b = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      sin_b = 8'(k); run_b = (k >= 20);
      tick();
    end
    chk("wrap_done_state", 32'(state_b), 5);
    chk("wrap_last_addr", 32'(wr_addr_b), 7);
    sv_b = 1'b0; run_b = 1'b0;
    tick();
    chk("wrap_trig", 32'(trig_b), 4);
    chk("wrap_start_addr", 32'(saddr_b), 15);
    chk("wrap_nwrites", 32'(wb_addr.size() - base), 24);
    bad = 0;
    for (int i = 0; i < 24 && base + i < wb_addr.size(); i++)
      if (wb_addr[base+i] != (i % 16)) bad++;
    chk("wrap_addr_seq", 32'(bad), 0);

    // ---- Saturation on 4-bit instance: pre=10 post=12 -> post limited to 5 ----
    base = wb_addr.size();
    pre_b = 4'd10; post_b = 4'd12; run_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    sv_b = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      sin_b = 8'(k);
      tick();
      if (k == 13) chk("sat_still_post", 32'(state_b), 4);
    end
    chk("sat_done_state", 32'(state_b), 5);
    sv_b = 1'b0; run_b = 1'b0;
    tick();
    chk("sat_trig", 32'(trig_b), 10);
    chk("sat_start_addr", 32'(saddr_b), 0);
    chk("sat_nwrites", 32'(wb_addr.size() - base), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Sequences one logic-analyzer acquisition around the sampler/trigger datapath.
- Issues the arm pulse and enforces a programmable pre-trigger fill.
- Waits for the trigger's run flag, then counts post-trigger samples.
- Drives write address/enable of a circular sample RAM; reports the trigger location and readout start address to the host interface.

Parameters:
ADDR_WIDTH, 10, sample RAM address width; DEPTH = 2**ADDR_WIDTH samples
SAMPLE_WIDTH, 8, width of the sample word (passed through to RAM data)

Ports:
system_clock  in  1  single design clock
reset_n  in  1  asynchronous active-low reset
start  in  1  host request to begin acquisition (level sampled per cycle)
abort  in  1  host request to cancel acquisition
pre_count  in  ADDR_WIDTH  samples to keep before trigger
post_count  in  ADDR_WIDTH  samples to capture after trigger
sample_in  in  SAMPLE_WIDTH  sampler output data
sample_valid  in  1  sampler output strobe
run  in  1  trigger-fired flag from trigger unit (sticky until next arm)
arm  out  1  one-cycle arm/reset pulse to sampler and trigger
wr_en  out  1  RAM write enable
wr_addr  out  ADDR_WIDTH  RAM write address
wr_data  out  SAMPLE_WIDTH  RAM write data (= sample_in, registered with wr_en)
trig_addr  out  ADDR_WIDTH  address of first sample written with run high
start_addr  out  ADDR_WIDTH  oldest valid sample address (trig_addr - pre_count, mod DEPTH)
done  out  1  acquisition complete, outputs stable
busy  out  1  high in ARM/PRETRIG/WAIT_TRIG/POSTTRIG
state  out  3  encoded FSM state for status register

Behaviour:
- Reset: state=IDLE; all outputs 0, including wr_addr, trig_addr and start_addr.
- FSM: IDLE(0), ARM(1), PRETRIG(2), WAIT_TRIG(3), POSTTRIG(4), DONE(5).
- IDLE/DONE + start → ARM. pre_count and post_count latch on that edge; later changes are ignored until the next start. pre_count above DEPTH-1 is not possible by width; pre_count+post_count > DEPTH-1 saturates post to DEPTH-1-pre.
- ARM: arm=1 for exactly one cycle; wr_addr cleared to 0; counters cleared.
  - Next state is PRETRIG, or WAIT_TRIG if latched pre=0.
- Write rule: in PRETRIG/WAIT_TRIG/POSTTRIG, each sample_valid produces one registered write.
  - wr_en, wr_data and wr_addr are valid the cycle after sample_valid (1-cycle latency).
  - wr_addr post-increments after each write, wrapping DEPTH-1 → 0.
- PRETRIG: count writes. run is ignored. When count reaches pre → WAIT_TRIG.
- WAIT_TRIG: on the first sample_valid with run=1, trig_addr = address of that write and that write counts as post sample 1.
  - post=0 → DONE without writing that sample.
  - Else → POSTTRIG, or DONE directly if post=1.
  - run already high on entry is accepted on the first valid sample.
  - Writes continue circularly while waiting.
- POSTTRIG: count writes. When total post samples == post → DONE on the cycle after the last write is issued.
- DONE: done=1, busy=0, wr_en=0. start_addr = trig_addr - pre (mod DEPTH), registered on entry. Hold until start (rearm) or abort.
- abort (any state, highest priority over start/run/valid) → IDLE next cycle. wr_en is forced 0 that cycle. done cleared; trig_addr and start_addr cleared.
- start while busy: ignored.
- run falling mid-POSTTRIG: ignored.
- Async reset mid-operation: immediate return to reset values; no partial write completes.

Decomposition:
- Package capture_pkg: typedef enum logic[2:0] capture_state_t, with the state encodings above and the DEPTH-derived constants.
- One natural sub-module, circ_addr_counter: wrapping write-address counter with clear/increment and a modular subtract helper for start_addr.
- FSM and sample counters stay in capture_controller.

Test Plan:
- Reset then idle: reset_n low with random inputs → arm, wr_en, done, busy all 0; state=0.
- Basic capture: pre=4, post=3, valid every cycle, run rises after 10 samples → arm pulse 1 cycle; writes at addr 0..12; trig_addr=10; start_addr=6; done after write 12; exactly 13 writes.
- Early trigger: pre=4, run already high at arm → run ignored during PRETRIG; trig_addr=4; start_addr=0.
- Wrap: ADDR_WIDTH=4, pre=5, post=4, trigger after 20 samples → wr_addr wraps 15→0; trig_addr=4; start_addr=15; last write at addr 7.
- Abort: abort asserted in POSTTRIG with sample_valid high → no write that cycle; state=IDLE next cycle; done stays 0; a later start rearms normally.
- Edge configs: pre=0/post=0 → immediate WAIT_TRIG, DONE on the trigger sample with no write. start during WAIT_TRIG → ignored. Sparse valid (1 in 3 cycles) → counts only valid samples.
